// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_MADD_EN to enable the MADD/MSUB accumulate operations (ops 6/7).
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [5:0]       count, count_n;
    logic [2:0]       op_q, op_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             done_n;
    logic             multi_op;

    logic signed [2*WIDTH-1:0] ext_a, ext_b;
    logic [2*WIDTH-1:0]        prod_s, prod_u, result;
    logic [WIDTH-1:0]          quot, rem;

`ifdef MULDIV_MADD_EN
    assign multi_op = (op != OP_MTHI) && (op != OP_MTLO);
`else
    assign multi_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`endif

    assign busy   = (state == RUN);
    assign ext_a  = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign ext_b  = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_s = ext_a * ext_b;
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Final HI/LO value, computed from the latched operands and only committed at completion.
    always_comb begin
        result = {hi, lo};
        quot   = '0;
        rem    = '0;
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV, OP_DIVU: begin
                if (b_q == '0) begin
                    quot = '1;
                    rem  = a_q;
                end else if (op_q == OP_DIV && a_q == MOST_NEG && b_q == '1) begin
                    quot = MOST_NEG;
                    rem  = '0;
                end else if (op_q == OP_DIV) begin
                    quot = $signed(a_q) / $signed(b_q);
                    rem  = $signed(a_q) % $signed(b_q);
                end else begin
                    quot = a_q / b_q;
                    rem  = a_q % b_q;
                end
                result = {rem, quot};
            end
`ifdef MULDIV_MADD_EN
            OP_MADD: result = {hi, lo} + prod_s;
            OP_MSUB: result = {hi, lo} - prod_s;
`endif
            default: result = {hi, lo};
        endcase
    end

    always_comb begin
        state_n = state;
        count_n = count;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = hi;
        lo_n    = lo;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                // flush in the same cycle suppresses every kind of start, including MTHI/MTLO
                if (start && !flush) begin
                    if (op == OP_MTHI) begin
                        hi_n = src_a;
                    end else if (op == OP_MTLO) begin
                        lo_n = src_a;
                    end else if (multi_op) begin
                        state_n = RUN;
                        op_n    = op;
                        a_n     = src_a;
                        b_n     = src_b;
                        count_n = (op == OP_DIV || op == OP_DIVU) ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES);
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_n = IDLE;
                    count_n = '0;
                end else if (count == 6'd1) begin
                    state_n      = IDLE;
                    count_n      = '0;
                    {hi_n, lo_n} = result;
                    done_n       = 1'b1;
                end else begin
                    count_n = count - 6'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            op_q  <= op_n;
            a_q   <= a_n;
            b_q   <= b_n;
            hi    <= hi_n;
            lo    <= lo_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: vector table plus hand-written sequences
// for overlap, flush, reset and the optional MULDIV_MADD_EN accumulate ops.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
        int          exp_done;
    } vec_t;

    vec_t vecs[12];

    muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Issues one start, then observes 20 falling edges counting busy/done cycles
    // and flagging any change of hi/lo while busy is high.
    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output int busy_cnt, output int done_cnt, output int leak);
        logic [31:0] pre_hi, pre_lo;
        @(negedge clk);
        pre_hi = hi;
        pre_lo = lo;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; leak = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) begin
                busy_cnt++;
                if (hi !== pre_hi || lo !== pre_lo) leak = 1;
            end
            if (done) done_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check_output({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int bc, dc, lk;
        logic [31:0] save_hi, save_lo;

        vecs[0]  = '{"mult_neg",   OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  1};
        vecs[1]  = '{"multu_big",  OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5,  1};
        vecs[2]  = '{"div_neg",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1};
        vecs[3]  = '{"divu_zero",  OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 10, 1};
        vecs[4]  = '{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1};
        vecs[5]  = '{"div_zero",   OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 10, 1};
        vecs[6]  = '{"divu_big",   OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10, 1};
        vecs[7]  = '{"div_negdiv", OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1};
        vecs[8]  = '{"mult_min",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  1};
        vecs[9]  = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  1};
        vecs[10] = '{"mthi",       OP_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'h00000001, 0,  0};
        vecs[11] = '{"mtlo",       OP_MTLO,  32'h0000ABCD, 32'd0,        32'h00001234, 32'h0000ABCD, 0,  0};

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
        #2 reset = 1'b0;
        #1;
        check_output("reset_hi",   64'(hi),   64'd0);
        check_output("reset_lo",   64'(lo),   64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, bc, dc, lk);
            check_output({vecs[i].name, "_hi"},   64'(hi), 64'(vecs[i].exp_hi));
            check_output({vecs[i].name, "_lo"},   64'(lo), 64'(vecs[i].exp_lo));
            check_output({vecs[i].name, "_busy"}, 64'(bc), 64'(vecs[i].exp_busy));
            check_output({vecs[i].name, "_done"}, 64'(dc), 64'(vecs[i].exp_done));
            if (vecs[i].exp_busy > 0) check_output({vecs[i].name, "_stable"}, 64'(lk), 64'd0);
        end

        // MTHI issued while a DIV is running must be dropped
        save_hi = hi;
        @(negedge clk);
        start = 1'b1; op = OP_DIV; src_a = 32'hFFFFFFF9; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = OP_MTHI; src_a = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check_output("ovl_busy", 64'(busy), 64'd1);
        check_output("ovl_hold", 64'(hi),   64'(save_hi));
        wait_idle("ovl");
        check_output("ovl_hi", 64'(hi), 64'hFFFFFFFF);
        check_output("ovl_lo", 64'(lo), 64'hFFFFFFFD);

        // Flush four cycles into a DIV: busy drops, no done, HI/LO untouched
        apply_stimulus(OP_MTHI, 32'h11, 32'd0, bc, dc, lk);
        apply_stimulus(OP_MTLO, 32'h22, 32'd0, bc, dc, lk);
        @(negedge clk);
        start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_output("flush_busy", 64'(busy), 64'd0);
        dc = 0; bc = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) dc++;
            if (busy) bc++;
            @(negedge clk);
        end
        check_output("flush_done",  64'(dc), 64'd0);
        check_output("flush_rerun", 64'(bc), 64'd0);
        check_output("flush_hi",    64'(hi), 64'h11);
        check_output("flush_lo",    64'(lo), 64'h22);

        // flush and start together: start loses, even for MTHI
        start = 1'b1; flush = 1'b1; op = OP_MTHI; src_a = 32'h99;
        @(negedge clk);
        op = OP_MULT; src_a = 32'd3; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_output("fs_hi",   64'(hi),   64'h11);
        check_output("fs_lo",   64'(lo),   64'h22);
        check_output("fs_busy", 64'(busy), 64'd0);

        // Accumulate ops depend on the build configuration
        apply_stimulus(OP_MTHI, 32'd1, 32'd0, bc, dc, lk);
        apply_stimulus(OP_MTLO, 32'd2, 32'd0, bc, dc, lk);
        apply_stimulus(OP_MADD, 32'd3, 32'd4, bc, dc, lk);
`ifdef MULDIV_MADD_EN
        check_output("madd_hi",   64'(hi), 64'd1);
        check_output("madd_lo",   64'(lo), 64'd14);
        check_output("madd_busy", 64'(bc), 64'd5);
        check_output("madd_done", 64'(dc), 64'd1);
        apply_stimulus(OP_MSUB, 32'd3, 32'd4, bc, dc, lk);
        check_output("msub_hi",   64'(hi), 64'd1);
        check_output("msub_lo",   64'(lo), 64'd2);
        check_output("msub_busy", 64'(bc), 64'd5);
`else
        check_output("madd_hi",   64'(hi), 64'd1);
        check_output("madd_lo",   64'(lo), 64'd2);
        check_output("madd_busy", 64'(bc), 64'd0);
        check_output("madd_done", 64'(dc), 64'd0);
        apply_stimulus(OP_MSUB, 32'd3, 32'd4, bc, dc, lk);
        check_output("msub_lo",   64'(lo), 64'd2);
        check_output("msub_busy", 64'(bc), 64'd0);
`endif

        // Asynchronous reset in the middle of a MULT
        @(negedge clk);
        start = 1'b1; op = OP_MULT; src_a = 32'd5; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_output("rst_mid_hi",   64'(hi),   64'd0);
        check_output("rst_mid_lo",   64'(lo),   64'd0);
        check_output("rst_mid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(OP_MULT, 32'd2, 32'd2, bc, dc, lk);
        check_output("post_rst_lo",   64'(lo), 64'd4);
        check_output("post_rst_hi",   64'(hi), 64'd0);
        check_output("post_rst_busy", 64'(bc), 64'd5);
        check_output("post_rst_done", 64'(dc), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32: operand and HI/LO width; legal values 8 to 64.
REQ-002 The block SHALL provide parameter MUL_CYCLES, default 5: busy cycles for MULT/MULTU/MADD/MSUB; legal values 1 to 63.
REQ-003 The block SHALL provide parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU; legal values 1 to 63.
REQ-004 The block SHALL provide port `clk`, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL provide port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL provide port `start`, input, 1 bit: operation request, sampled on the rising edge.
REQ-007 The block SHALL provide port `op`, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-008 The block SHALL provide ports `src_a` and `src_b`, input, WIDTH bits each: operands (rs, rt).
REQ-009 The block SHALL provide port `flush`, input, 1 bit: abort any in-flight operation.
REQ-010 The block SHALL provide port `busy`, output, 1 bit: a multi-cycle operation is in flight.
REQ-011 The block SHALL provide port `done`, output, 1 bit: one-cycle pulse on completion.
REQ-012 The block SHALL provide ports `hi` and `lo`, output, WIDTH bits each: architectural HI/LO registers.

Function
REQ-013 A start with busy=0 and flush=0 SHALL be accepted at rising edge T; `op`, `src_a` and `src_b` are latched at T.
REQ-014 A start with busy=1 SHALL be ignored, with no latch and no state change.
REQ-015 An accepted op 0-3 or 6-7 SHALL hold busy=1 for exactly N cycles after T, where N is MUL_CYCLES or DIV_CYCLES.
REQ-016 At edge T+N, hi/lo SHALL update and busy SHALL fall; done SHALL be 1 for the cycle after T+N only.
REQ-017 MTHI/MTLO SHALL write hi or lo at T with no busy and no done; the other register is unchanged.
REQ-018 MULT/MULTU SHALL produce the 2*WIDTH product, signed or unsigned; {hi,lo} = product.
REQ-019 MADD/MSUB SHALL compute {hi,lo} +/- the signed product, modulo 2^(2*WIDTH).
REQ-020 DIV/DIVU SHALL set lo = quotient truncated toward zero and hi = remainder, with the sign of the remainder equal to the sign of the dividend.
REQ-021 Divide by zero SHALL produce lo = all ones and hi = src_a, in both signed and unsigned modes.
REQ-022 Signed DIV of the most-negative value by -1 SHALL produce lo = most-negative value and hi = 0.
REQ-023 flush=1 SHALL clear busy at the next edge, leave hi/lo unchanged, and produce no done pulse.
REQ-024 When flush and start occur in the same cycle, flush SHALL win and start SHALL be ignored, including MTHI/MTLO.
REQ-025 hi/lo SHALL change only at completion, at an MTHI/MTLO write, or at reset; no intermediate values are visible.
REQ-026 The cycle counter SHALL be 6 bits; hi/lo SHALL hold their values between operations indefinitely.

Reset
REQ-027 reset=0 SHALL asynchronously force hi=0, lo=0, busy=0, done=0, clear the counter and discard latched operands, including mid-operation.
REQ-028 After reset is released, the first accepted start SHALL occur no earlier than the first rising edge with reset=1.

Configuration
REQ-029 With macro MULDIV_MADD_EN defined, ops 6/7 SHALL behave as in REQ-019.
REQ-030 Without MULDIV_MADD_EN, ops 6/7 SHALL be accepted as no-ops: no busy, no done, hi/lo unchanged; no accumulate logic is synthesised.

Verification
REQ-031 MULT with src_a=0xFFFFFFFE and src_b=3 SHALL give busy for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA, with done pulsed once.
REQ-032 DIV with src_a=-7 and src_b=2 SHALL give busy for 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU with src_a=7 and src_b=0 SHALL give lo=0xFFFFFFFF and hi=7.
REQ-033 A DIV started followed by start of MTHI 5 at cycle 3 SHALL have the MTHI ignored; final hi SHALL be the remainder.
REQ-034 MTHI 1, MTLO 2, then MADD with src_a=3 and src_b=4 SHALL give hi=1 and lo=14 after 5 cycles when the macro is defined, and hi=1, lo=2 with busy never set when it is not.
REQ-035 flush asserted at cycle 4 of a DIV SHALL give busy=0 at the next edge, no done pulse, and hi/lo equal to their pre-DIV values.
REQ-036 reset asserted mid-MULT between edges SHALL immediately give hi=lo=0 and busy=0; a new MULT with src_a=2 and src_b=2 SHALL then give lo=4.
